// File: rtl/bwt_mem_req_serializer_pkg.sv
// Shared constants for the BWT memory-request serializer: issue FSM encoding,
// k/l tag select values and default widths.
package bwt_mem_req_serializer_pkg;

  localparam int ADDR_W_DEFAULT       = 42;
  localparam int RN_W_DEFAULT         = 6;
  localparam int DEPTH_DEFAULT        = 16;
  localparam int AFULL_MARGIN_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEND_K = 2'd1,
    ST_SEND_L = 2'd2
  } state_e;

  localparam logic SEL_K = 1'b0;
  localparam logic SEL_L = 1'b1;

endpackage

// File: rtl/bwt_mem_req_serializer_fifo.sv
// Synchronous FIFO for k/l request entries; accepts a push while full when a
// pop happens in the same cycle. Head data is read straight from storage.
module bwt_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok_s, pop_ok_s;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == CW'(0));
  assign pop_ok_s  = pop_i & ~empty_o;
  assign push_ok_s = push_i & (~full_o | pop_ok_s);
  assign rdata_o   = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/bwt_mem_req_serializer.sv
// Buffers k/l occurrence-lookup pairs and issues them as two tagged reads
// (k then l) on a single valid/ready memory port, with early upstream stall.
module bwt_mem_req_serializer
  import bwt_mem_req_serializer_pkg::*;
#(
  parameter int DEPTH        = DEPTH_DEFAULT,
  parameter int ADDR_W       = ADDR_W_DEFAULT,
  parameter int RN_W         = RN_W_DEFAULT,
  parameter int AFULL_MARGIN = AFULL_MARGIN_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       request_valid,
  input  logic [ADDR_W-1:0]          addr_k,
  input  logic [ADDR_W-1:0]          addr_l,
  input  logic [RN_W-1:0]            read_num,
  output logic                       stall_req,
  output logic                       mem_req_valid,
  output logic [ADDR_W-1:0]          mem_req_addr,
  output logic [RN_W:0]              mem_req_tag,
  input  logic                       mem_req_ready,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       overflow_err
);

  localparam int ENTRY_W = RN_W + 2*ADDR_W;
  localparam int CNT_W   = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] STALL_LVL = CNT_W'(DEPTH - AFULL_MARGIN);

  state_e              state_q, state_d;
  logic                pop_s;
  logic                full_s, empty_s;
  logic [CNT_W-1:0]    count_s;
  logic [ENTRY_W-1:0]  head_s;
  logic [ADDR_W-1:0]   head_k_s, head_l_s;
  logic [RN_W-1:0]     head_rn_s;
  logic                stall_q, stall_d;
  logic                overflow_q, overflow_d;

  assign {head_rn_s, head_k_s, head_l_s} = head_s;

  bwt_req_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (request_valid),
    .pop_i   (pop_s),
    .wdata_i ({read_num, addr_k, addr_l}),
    .rdata_o (head_s),
    .count_o (count_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // Issue FSM next state. Leaving SEND_L goes straight to SEND_K when any
  // entry survives the pop (including one pushed this cycle), so pairs stream.
  always_comb begin
    state_d = state_q;
    pop_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty_s) state_d = ST_SEND_K;
        else          state_d = ST_IDLE;
      end
      ST_SEND_K: begin
        if (mem_req_ready) state_d = ST_SEND_L;
        else               state_d = ST_SEND_K;
      end
      ST_SEND_L: begin
        if (mem_req_ready) begin
          pop_s = 1'b1;
          if ((count_s > CNT_W'(1)) || request_valid) state_d = ST_SEND_K;
          else                                        state_d = ST_IDLE;
        end else begin
          state_d = ST_SEND_L;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Memory port decode from registered state and the FIFO head only.
  always_comb begin
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    mem_req_tag   = '0;
    case (state_q)
      ST_SEND_K: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = head_k_s;
        mem_req_tag   = {head_rn_s, SEL_K};
      end
      ST_SEND_L: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = head_l_s;
        mem_req_tag   = {head_rn_s, SEL_L};
      end
      default: begin
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        mem_req_tag   = '0;
      end
    endcase
  end

  // Stall follows last cycle's occupancy; overflow latches any dropped push.
  always_comb begin
    stall_d    = (count_s >= STALL_LVL);
    overflow_d = overflow_q | (request_valid & full_s & ~pop_s);
  end

  // State, stall and sticky error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      stall_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      stall_q    <= stall_d;
      overflow_q <= overflow_d;
    end
  end

  assign stall_req    = stall_q;
  assign overflow_err = overflow_q;
  assign fifo_count   = count_s;

endmodule

// File: doc/bwt_mem_req_serializer.md
Name: bwt_mem_req_serializer

Overview:
- Sits directly downstream of the backward datapath's memory-request outputs (`request_valid`, `addr_k`, `addr_l`, `read_num`).
- Buffers each k/l occurrence-lookup pair in a FIFO.
- Serializes each pair into two single-address reads on one valid/ready memory port. Each read carries a tag, so returned cnt data can be matched to its read and to k vs l.
- Asserts `stall_req` early enough that the upstream pipeline freezes before the buffer overflows.

Parameters:
- DEPTH, 16, FIFO entries (power of 2, ≥4).
- ADDR_W, 42, memory address width; matches `addr_k`/`addr_l`.
- RN_W, 6, read-number width; instantiated with `READ_NUM_WIDTH.
- AFULL_MARGIN, 4, free-slot threshold for `stall_req`; must be ≥ the upstream pipeline depth between stall and `request_valid`.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- request_valid  in  1  push a k/l request pair.
- addr_k  in  ADDR_W  k-side address.
- addr_l  in  ADDR_W  l-side address.
- read_num  in  RN_W  read slot of the request.
- stall_req  out  1  FIFO almost full; upstream must stop issuing.
- mem_req_valid  out  1  memory read request valid.
- mem_req_addr  out  ADDR_W  read address.
- mem_req_tag  out  RN_W+1  {read_num, sel}; sel=0 means k, sel=1 means l.
- mem_req_ready  in  1  memory accepts the request this cycle.
- fifo_count  out  $clog2(DEPTH+1)  occupied entries.
- overflow_err  out  1  sticky; a push was dropped.

Behaviour:
- Reset (rst=0, async):
  - FIFO emptied; state IDLE.
  - Outputs: mem_req_valid=0, mem_req_addr=0, mem_req_tag=0, fifo_count=0, stall_req=0, overflow_err=0.
  - Reset mid-transaction abandons the in-flight request; no further handshake is owed.
- Entry format: {read_num, addr_k, addr_l}, stored unmodified.
- Push:
  - Condition: request_valid && (count<DEPTH || pop this cycle).
  - If request_valid && count==DEPTH && no pop: entry dropped, overflow_err set to 1 until reset.
  - Simultaneous push and pop when full is accepted; count unchanged.
- FIFO pointers: log2(DEPTH) bits, natural wrap-around.
- count update: +1 on push-only, −1 on pop-only, unchanged on both or neither.
- stall_req = (count ≥ DEPTH−AFULL_MARGIN). It is registered, i.e. it reflects the count at the end of the previous cycle.
- Issue FSM states: IDLE, SEND_K, SEND_L.
  - IDLE: if count>0, go to SEND_K next cycle.
  - SEND_K: mem_req_valid=1, addr=head.addr_k, tag={head.read_num,0}. On mem_req_ready go to SEND_L.
  - SEND_L: mem_req_valid=1, addr=head.addr_l, tag={head.read_num,1}.
    - On mem_req_ready: pop head.
    - Then go to SEND_K if entries remain after the pop (a same-cycle push counts), else IDLE.
- Handshake rules:
  - Transfer occurs when mem_req_valid && mem_req_ready.
  - While valid is high and ready is low, addr and tag hold stable.
  - valid never drops without a transfer.
  - There is no combinational path from mem_req_ready to any output.
  - Outputs are registers or decode of registered state plus the FIFO head.
- Latency:
  - Push at cycle t into an empty FIFO gives mem_req_valid at t+2 (t+1 write, IDLE→SEND_K).
  - Back-to-back entries with ready held high give one request per cycle and no bubble between pairs.
- Ordering: requests leave in strict push order; k always precedes l for the same entry.
- mem_req_addr and mem_req_tag are 0 in IDLE.

Decomposition:
- Shared package (pipeline header):
  - State encoding constants ST_IDLE=0, ST_SEND_K=1, ST_SEND_L=2.
  - Tag select constants SEL_K=0, SEL_L=1.
  - Default ADDR_W=42.
- One natural sub-module: bwt_req_fifo.
  - Synchronous FIFO with count, full, empty, and simultaneous push/pop support.
  - Parameterized by width and DEPTH.
  - The FSM and output muxing stay in bwt_mem_req_serializer.

Test Plan:
- Single request, no memory backpressure:
  - Stimulus: at t0 push addr_k=0x10, addr_l=0x20, read_num=3; ready=1.
  - Required: t0+2 addr=0x10 tag={3,0}; t0+3 addr=0x20 tag={3,1}; t0+4 valid=0, fifo_count=0.
- Backpressure hold:
  - Stimulus: ready=0 for 5 cycles during SEND_K.
  - Required: valid, addr=0x10 and tag stay constant for all 5 cycles. After ready rises, exactly one k-transfer then the l-request.
- Fill, stall and overflow (DEPTH=16, AFULL_MARGIN=4, ready=0):
  - Stimulus: push 17 entries on consecutive cycles.
  - Required: stall_req rises the cycle after count reaches 12; count saturates at 16; 17th push dropped; overflow_err=1 sticky.
- Push and pop when full:
  - Stimulus: with count=16, push on the same cycle the SEND_L handshake completes.
  - Required: count stays 16; new entry issued last; overflow_err stays 0.
- Streaming order:
  - Stimulus: push read_num 0..7 with addr_k=n, addr_l=0x100+n; ready=1.
  - Required: 16 consecutive transfers k0,l0,k1,l1,…,k7,l7 with no idle cycle between them.
- Reset mid-operation:
  - Stimulus: assert rst=0 during SEND_L with count=5.
  - Required: outputs go to zero immediately (asynchronously); after release, no request is issued until a new push.
